// File: rtl/aes_seq_pkg.sv
// aes_seq_pkg -- shared types and constants for the AES byte-serial sequencer.
//   aes_seq_state_t : sequencer FSM state encoding
//   BLOCK_BYTES     : bytes per key/block frame
//   BYTE_CNT_W      : width of the byte counter
//   WAIT_CNT_W      : width of the core multicycle wait counter
//   FIPS_*          : FIPS-197 reference vectors (bench use)
package aes_seq_pkg;

    localparam int BLOCK_BYTES = 16;
    localparam int BYTE_CNT_W  = 4;
    localparam int WAIT_CNT_W  = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD_KEY = 3'd1,
        LOAD_BLK = 3'd2,
        RUN      = 3'd3,
        OUT      = 3'd4
    } aes_seq_state_t;

    localparam logic [127:0] FIPS_KEY     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT      = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT      = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    // AES-128 of an all-zero block under an all-zero key.
    localparam logic [127:0] ZERO_KEY_CT  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

endpackage

// File: rtl/aes_byte_shreg.sv
// aes_byte_shreg -- byte-wide shift register with parallel load.
//   clk, rst_n : clock, async active-low reset (clears to 0)
//   en         : global enable; low holds contents
//   load       : parallel load of load_data (wins over shift)
//   shift      : shift left one byte, shift_in enters at the bottom
//   q          : register contents; q[WIDTH-1 -: 8] is the oldest byte
module aes_byte_shreg #(
    parameter int WIDTH = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift,
    input  logic [7:0]       shift_in,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (en) begin
            if (load)       q_d = load_data;
            else if (shift) q_d = {q_q[WIDTH-9:0], shift_in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q_q <= '0;
        else        q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/aes_io_sequencer.sv
// aes_io_sequencer -- byte-serial front end for a combinational AES core.
// Collects a 128-bit key or block over an 8-bit ready/valid stream, holds the
// core inputs for CORE_WAIT+1 cycles, captures the result and streams it out.
//   clk/rst_n            : clock, async active-low reset
//   ena                  : global enable, low freezes every register
//   abort                : return to IDLE, key retained, any block dropped
//   in_valid/in_ready/in_data/in_key/in_dec : input byte stream
//   out_valid/out_ready/out_data/out_last   : output byte stream
//   busy, key_loaded     : status
//   core_key/core_block/core_dec            : AES core inputs
//   core_enc_result/core_dec_result         : AES core outputs
// Build option: AES_SEQ_DECRYPT_EN enables decrypt; when undefined core_dec
// stays 0 and core_dec_result is never used so the decrypt core can be pruned.
module aes_io_sequencer
    import aes_seq_pkg::aes_seq_state_t;
    import aes_seq_pkg::IDLE;
    import aes_seq_pkg::LOAD_KEY;
    import aes_seq_pkg::LOAD_BLK;
    import aes_seq_pkg::RUN;
    import aes_seq_pkg::OUT;
    import aes_seq_pkg::BYTE_CNT_W;
    import aes_seq_pkg::WAIT_CNT_W;
#(
    parameter int CORE_WAIT   = 2,
    parameter int BLOCK_BYTES = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ena,
    input  logic         abort,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_data,
    input  logic         in_key,
    input  logic         in_dec,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [7:0]   out_data,
    output logic         out_last,
    output logic         busy,
    output logic         key_loaded,
    output logic [127:0] core_key,
    output logic [127:0] core_block,
    output logic         core_dec,
    input  logic [127:0] core_enc_result,
    input  logic [127:0] core_dec_result
);

    localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(BLOCK_BYTES - 1);

    aes_seq_state_t          state_q, state_d;
    logic [BYTE_CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [WAIT_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                    key_loaded_q, key_loaded_d;
    logic                    dec_q, dec_d;

    logic                    key_shift, blk_shift, res_load, res_shift;
    logic                    in_hs, out_hs, last_byte, dec_sel;
    logic [127:0]            result_sel, res_q;

`ifdef AES_SEQ_DECRYPT_EN
    assign dec_sel    = in_dec;
    assign result_sel = dec_q ? core_dec_result : core_enc_result;
`else
    assign dec_sel    = 1'b0;
    assign result_sel = core_enc_result;
    logic unused_dec;
    assign unused_dec = ^{core_dec_result, in_dec};
`endif

    assign in_ready  = (state_q == IDLE) || (state_q == LOAD_KEY) || (state_q == LOAD_BLK);
    assign out_valid = (state_q == OUT);
    assign out_last  = out_valid && (byte_cnt_q == LAST_BYTE);
    assign out_data  = res_q[127:120];
    assign busy      = (state_q != IDLE);
    assign key_loaded = key_loaded_q;
    assign core_dec  = dec_q;

    assign in_hs     = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;
    assign last_byte = (byte_cnt_q == LAST_BYTE);

    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        key_loaded_d = key_loaded_q;
        dec_d        = dec_q;
        key_shift    = 1'b0;
        blk_shift    = 1'b0;
        res_load     = 1'b0;
        res_shift    = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_hs) begin
                    byte_cnt_d = BYTE_CNT_W'(1);
                    if (in_key) begin
                        state_d   = LOAD_KEY;
                        key_shift = 1'b1;
                    end else begin
                        state_d   = LOAD_BLK;
                        blk_shift = 1'b1;
                        dec_d     = dec_sel;
                    end
                end
            end
            LOAD_KEY: begin
                if (in_hs) begin
                    key_shift = 1'b1;
                    if (last_byte) begin
                        state_d      = IDLE;
                        byte_cnt_d   = '0;
                        key_loaded_d = 1'b1;
                    end else begin
                        byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
                    end
                end
            end
            LOAD_BLK: begin
                if (in_hs) begin
                    blk_shift = 1'b1;
                    if (last_byte) begin
                        state_d    = RUN;
                        byte_cnt_d = '0;
                        wait_cnt_d = WAIT_CNT_W'(CORE_WAIT);
                    end else begin
                        byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
                    end
                end
            end
            RUN: begin
                // Core inputs have been stable for CORE_WAIT+1 cycles when
                // the counter is seen at zero; capture then.
                if (wait_cnt_q == '0) begin
                    res_load = 1'b1;
                    state_d  = OUT;
                end else begin
                    wait_cnt_d = wait_cnt_q - WAIT_CNT_W'(1);
                end
            end
            OUT: begin
                if (out_hs) begin
                    if (last_byte) begin
                        state_d    = IDLE;
                        byte_cnt_d = '0;
                    end else begin
                        res_shift  = 1'b1;
                        byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort overrides everything, including a same-cycle handshake.
        if (abort) begin
            state_d      = IDLE;
            byte_cnt_d   = '0;
            wait_cnt_d   = wait_cnt_q;
            key_loaded_d = key_loaded_q;
            dec_d        = dec_q;
            key_shift    = 1'b0;
            blk_shift    = 1'b0;
            res_load     = 1'b0;
            res_shift    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            byte_cnt_q   <= '0;
            wait_cnt_q   <= '0;
            key_loaded_q <= 1'b0;
            dec_q        <= 1'b0;
        end else if (ena) begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            key_loaded_q <= key_loaded_d;
            dec_q        <= dec_d;
        end
    end

    aes_byte_shreg #(.WIDTH(128)) u_key_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (ena),
        .load      (1'b0),
        .load_data ('0),
        .shift     (key_shift),
        .shift_in  (in_data),
        .q         (core_key)
    );

    aes_byte_shreg #(.WIDTH(128)) u_blk_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (ena),
        .load      (1'b0),
        .load_data ('0),
        .shift     (blk_shift),
        .shift_in  (in_data),
        .q         (core_block)
    );

    aes_byte_shreg #(.WIDTH(128)) u_res_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (ena),
        .load      (res_load),
        .load_data (result_sel),
        .shift     (res_shift),
        .shift_in  (8'h00),
        .q         (res_q)
    );

endmodule

// File: tb/tb_aes_io_sequencer.sv
// tb_aes_io_sequencer -- scoreboard bench for aes_io_sequencer. A stub AES
// core returns the FIPS-197 vectors for known inputs and a fixed mix otherwise.
module tb_aes_io_sequencer;
    import aes_seq_pkg::*;

    localparam int CORE_WAIT = 2;
    localparam logic [127:0] MIX = 128'h5a5a5a5a_a5a5a5a5_0f0f0f0f_f0f0f0f0;

    logic         clk = 1'b0;
    logic         rst_n, ena, abort;
    logic         in_valid, in_ready, in_key, in_dec;
    logic [7:0]   in_data;
    logic         out_valid, out_ready, out_last;
    logic [7:0]   out_data;
    logic         busy, key_loaded, core_dec;
    logic [127:0] core_key, core_block, core_enc_result, core_dec_result;

    int n_cmp = 0;
    int n_bad = 0;
    int hs_cnt = 0;
    logic bp = 1'b0;
    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

    aes_io_sequencer #(.CORE_WAIT(CORE_WAIT), .BLOCK_BYTES(16)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_key(in_key), .in_dec(in_dec),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .key_loaded(key_loaded),
        .core_key(core_key), .core_block(core_block), .core_dec(core_dec),
        .core_enc_result(core_enc_result), .core_dec_result(core_dec_result)
    );

    function automatic logic [127:0] stub_enc(input logic [127:0] k, input logic [127:0] b);
        if (k == FIPS_KEY && b == FIPS_PT) return FIPS_CT;
        if (k == '0 && b == '0)            return ZERO_KEY_CT;
        return b ^ k ^ MIX;
    endfunction

    function automatic logic [127:0] stub_dec(input logic [127:0] k, input logic [127:0] b);
        if (k == FIPS_KEY && b == FIPS_CT) return FIPS_PT;
        return ~(b ^ k);
    endfunction

    assign core_enc_result = stub_enc(core_key, core_block);
    assign core_dec_result = stub_dec(core_key, core_block);

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_result(input logic [127:0] r);
        for (int i = 0; i < 16; i++) exp_q.push_back({(i == 15), r[127-8*i -: 8]});
    endtask

    task automatic send_frame(input logic key, input logic dec, input logic [127:0] d, input int nb);
        for (int i = 0; i < nb; i++) begin
            int t;
            in_valid = 1'b1;
            in_key   = key;
            in_dec   = dec;
            in_data  = d[127-8*i -: 8];
            t = 0;
            @(negedge clk);
            while (!in_ready && t < 100) begin
                @(negedge clk);
                t++;
            end
            if (t == 100) chk("in_ready_timeout", 128'(0), 128'(1));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("idle_timeout", 128'(n < 1000), 128'(1));
    endtask

    // Cycles from the last input handshake edge until out_valid is seen.
    task automatic measure_lat(input int start, output int lat);
        lat = start;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // Scoreboard: pop on every output handshake, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && ena && !abort && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", 128'(out_data), 128'hx);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    chk("out_data", 128'(out_data), 128'(e[7:0]));
                    chk("out_last", 128'(out_last), 128'(e[8]));
                    hs_cnt++;
                    if (e[8]) begin
                        chk("busy_last", 128'(busy), 128'(1));
                        @(posedge clk);
                        #1;
                        if (rst_n) begin
                            chk("busy_after", 128'(busy), 128'(0));
                            chk("ov_after", 128'(out_valid), 128'(0));
                        end
                    end
                end
            end
        end
    end

    // Backpressure toggler, offset from the driver's #1 updates.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (bp) out_ready = ~out_ready;
        end
    end

    initial begin
        int lat;
        logic [127:0] rb;
        rst_n = 1'b0; ena = 1'b1; abort = 1'b0;
        in_valid = 1'b0; in_key = 1'b0; in_dec = 1'b0; in_data = 8'h00;
        out_ready = 1'b1;
        #12;
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_key_loaded", 128'(key_loaded), 128'(0));
        chk("rst_out_data", 128'(out_data), 128'(0));
        chk("rst_core_key", core_key, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Key frame
        send_frame(1'b1, 1'b0, FIPS_KEY, 16);
        chk("key_loaded", 128'(key_loaded), 128'(1));
        chk("key_busy", 128'(busy), 128'(0));
        chk("core_key", core_key, FIPS_KEY);

        // FIPS encrypt with latency check
        push_result(FIPS_CT);
        send_frame(1'b0, 1'b0, FIPS_PT, 16);
        chk("run_in_ready", 128'(in_ready), 128'(0));
        measure_lat(0, lat);
        chk("latency", 128'(lat), 128'(CORE_WAIT + 1));
        wait_idle();

        // Decrypt request: honoured only in the decrypt build
`ifdef AES_SEQ_DECRYPT_EN
        push_result(FIPS_PT);
        send_frame(1'b0, 1'b1, FIPS_CT, 16);
        chk("core_dec", 128'(core_dec), 128'(1));
`else
        push_result(FIPS_CT ^ FIPS_KEY ^ MIX);
        send_frame(1'b0, 1'b1, FIPS_CT, 16);
        chk("core_dec", 128'(core_dec), 128'(0));
`endif
        wait_idle();

        // Backpressure
        out_ready = 1'b0;
        push_result(FIPS_CT);
        send_frame(1'b0, 1'b0, FIPS_PT, 16);
        bp = 1'b1;
        wait_idle();
        bp = 1'b0;
        out_ready = 1'b1;

        // Abort mid-block with a colliding byte
        send_frame(1'b0, 1'b0, 128'hdeadbeef_01234567_89abcdef_00000000, 7);
        in_valid = 1'b1; in_data = 8'h77; abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; in_valid = 1'b0;
        chk("abort_busy", 128'(busy), 128'(0));
        chk("abort_key_loaded", 128'(key_loaded), 128'(1));
        push_result(FIPS_CT);
        send_frame(1'b0, 1'b0, FIPS_PT, 16);
        wait_idle();

        // Arbitrary block under the FIPS key
        rb = {$urandom, $urandom, $urandom, $urandom};
        push_result(rb ^ FIPS_KEY ^ MIX);
        send_frame(1'b0, 1'b0, rb, 16);
        wait_idle();

        // ena low for 10 cycles during RUN
        push_result(FIPS_CT);
        send_frame(1'b0, 1'b0, FIPS_PT, 16);
        @(posedge clk); #1;
        ena = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("freeze_busy", 128'(busy), 128'(1));
        chk("freeze_ov", 128'(out_valid), 128'(0));
        ena = 1'b1;
        measure_lat(11, lat);
        chk("freeze_latency", 128'(lat), 128'(CORE_WAIT + 1 + 10));
        wait_idle();

        // Reset in the middle of OUT after 5 bytes
        begin
            int base, t;
            push_result(FIPS_CT);
            send_frame(1'b0, 1'b0, FIPS_PT, 16);
            base = hs_cnt;
            t = 0;
            while (hs_cnt < base + 5 && t < 200) begin
                @(posedge clk); #1;
                t++;
            end
            chk("out5_timeout", 128'(t < 200), 128'(1));
            rst_n = 1'b0;
            #1;
            chk("mid_rst_ov", 128'(out_valid), 128'(0));
            chk("mid_rst_key_loaded", 128'(key_loaded), 128'(0));
            chk("mid_rst_core_key", core_key, '0);
            exp_q.delete();
            @(posedge clk); #1;
            rst_n = 1'b1;
            @(posedge clk); #1;
        end
        push_result(ZERO_KEY_CT);
        send_frame(1'b0, 1'b0, 128'h0, 16);
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/aes_io_sequencer.md
Name: aes_io_sequencer

Overview:
Byte-serial controller that sequences the combinational AES encrypt/decrypt datapath from the 8-bit Tiny Tapeout pins. Collects a 128-bit key and a 128-bit block over a ready/valid byte stream, then launches the core and holds its inputs stable for a programmable multicycle window. Captures the result and streams it back out as 16 bytes. Sits between the top-level pin wrapper and the AES_Encrypt/AES_Decrypt instances.

Parameters:
CORE_WAIT, 2, cycles core inputs are held stable before result capture (legal range 1..15)
BLOCK_BYTES, 16, bytes per key/block frame (fixed; parameterised only for readability)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  global enable; low freezes all state
abort  in  1  synchronous abort to IDLE; key is retained
in_valid  in  1  input byte valid
in_ready  out  1  input byte accepted when in_valid&in_ready
in_data  in  8  input byte, MSB-first within frame
in_key  in  1  frame type, sampled on first byte: 1=key, 0=block
in_dec  in  1  operation, sampled on first block byte: 1=decrypt
out_valid  out  1  output byte valid
out_ready  in  1  downstream accepts byte
out_data  out  8  result byte, MSB-first
out_last  out  1  high with 16th output byte
busy  out  1  high in any state except IDLE
key_loaded  out  1  a full key frame has been received since reset
core_key  out  128  key to AES core
core_block  out  128  block to AES core
core_dec  out  1  selects decrypt result
core_enc_result  in  128  AES_Encrypt output
core_dec_result  in  128  AES_Decrypt output

Behaviour:
- Clock and reset: one clock (clk); reset (rst_n) is asynchronous and active-low. All registers clear to 0, including key, block, result and counters. State resets to IDLE. in_ready=1 and all other outputs 0 after reset.
- ena=0: no state change in any register. Outputs hold their values.
- States: IDLE, LOAD_KEY, LOAD_BLK, RUN, OUT.
- IDLE: in_ready=1. An accepted byte with in_key=1 goes to LOAD_KEY with byte_cnt=1. An accepted byte with in_key=0 goes to LOAD_BLK with byte_cnt=1, and in_dec is latched into core_dec.
- LOAD_KEY/LOAD_BLK: in_ready=1. Each accepted byte shifts into the target register as reg <= {reg[119:0], in_data}. in_key/in_dec on non-first bytes are ignored.
- Key frame: on the 16th byte go to IDLE and set key_loaded=1. The key persists until reset or the next key frame. Partial key bytes are shifted into the live key register.
- Block frame: on the 16th byte go to RUN with wait_cnt=CORE_WAIT.
- A block frame is accepted even when key_loaded=0; the core uses the current key register.
- RUN: in_ready=0. core_key, core_block and core_dec are stable. wait_cnt decrements each cycle. When it reaches 0, the selected core result is captured into out_shreg and the state goes to OUT. Latency from last input byte to first out_valid is CORE_WAIT+1 cycles.
- OUT: out_valid=1, out_data=out_shreg[127:120], out_last=(byte_cnt==15). On out_valid&out_ready, out_shreg shifts left 8 and byte_cnt increments. The handshake with out_last goes to IDLE with byte_cnt=0 and out_valid=0 in the next cycle.
- Backpressure: out_ready=0 holds out_data and out_valid indefinitely.
- byte_cnt is 4 bits and wraps 15->0 only at frame end.
- abort=1 in any state: next state IDLE, byte_cnt=0, out_valid=0. The key register and key_loaded are unchanged. A partially loaded block is discarded.
- abort and a handshake in the same cycle: abort wins and the byte is dropped.
- Reset mid-operation: immediate return to reset values, including key and key_loaded.

Optional Feature:
Macro AES_SEQ_DECRYPT_EN.
- Defined: in_dec is honoured and core_dec selects core_dec_result.
- Undefined: core_dec is tied to 0 and in_dec is ignored. core_dec_result is unused, so synthesis can prune AES_Decrypt and save area. Encrypt results are identical in both builds.

Decomposition:
- Package aes_seq_pkg holds:
  - state enum aes_seq_state_t {IDLE, LOAD_KEY, LOAD_BLK, RUN, OUT}
  - BLOCK_BYTES=16
  - BYTE_CNT_W=4
  - WAIT_CNT_W=4
  - the FIPS-197 test key/plaintext/ciphertext constants for bench use
- One sub-module, aes_byte_shreg: a 128-bit byte shift register with load-parallel, shift-in and enable. Instantiated for the key, block and result registers.

Test Plan:
- FIPS-197 encrypt: key frame 00..0f, then block frame 00112233445566778899aabbccddeeff with in_dec=0 and out_ready=1. Output must be 69 c4 e0 d8 6a 7b 04 30 d8 cd b7 80 70 b4 c5 5a. out_last on 0x5a. First out_valid exactly CORE_WAIT+1 cycles after the 16th input byte.
- Decrypt (macro defined): same key retained, block 69c4e0d86a7b0430d8cdb78070b4c55a with in_dec=1. Output must be 00 11 22 ... ff.
- Backpressure: toggle out_ready 1/0 every cycle during OUT. Bytes must be unchanged and none lost. busy=1 until the cycle after the last handshake.
- Abort mid-block after 7 bytes, then a new full block 00112233..ff. Output must be 69c4e0d8...c55a, proving the key was retained and the partial block discarded.
- Reset mid-OUT after 5 bytes: out_valid=0 immediately and key_loaded=0. A block without a new key encrypts under the all-zero key and yields 66 e9 4b d4 ef 8a 2c 3b 88 4c fa 59 ca 34 2b 2e for plaintext 0.
- ena=0 for 10 cycles during RUN: wait_cnt frozen, and out_valid appears CORE_WAIT+1+10 cycles after the last input byte.
